// File: rtl/maverickOne_pkg.sv
// maverickOne shared definitions.
// BTB geometry, counter type and helpers.
package maverickOne_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NUM_BTB_SETS = 16;
  localparam int unsigned NUM_BTB_WAYS = 2;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t BTB_CTR_WEAK_TAKEN = 2'b10;

  function automatic btb_ctr_t btb_ctr_next(
    input btb_ctr_t c,
    input logic     taken
  );
    btb_ctr_t n;
    n = c;
    if (taken && c != 2'b11)
      n = c + 2'b01;
    else if (!taken && c != 2'b00)
      n = c - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/btb_replacement.sv
// Per-set BTB replacement state.
// Ports: lk_* lookup touch, up_* update touch,
//   full_alloc_i alloc into full set, victim_o.
// BTB_PLRU_EN: tree pseudo-LRU, else round-robin.
module btb_replacement
  import maverickOne_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = NUM_BTB_WAYS,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             lk_touch_i,
  input  logic [WAY_W-1:0] lk_way_i,
  input  logic             up_touch_i,
  input  logic [WAY_W-1:0] up_way_i,
  input  logic             full_alloc_i,
  output logic [WAY_W-1:0] victim_o
);

`ifdef BTB_PLRU_EN
  localparam int unsigned NB = NUM_WAYS - 1;

  logic [NB-1:0] r_tree;
  logic [NB-1:0] w_t1;
  logic [NB-1:0] w_t2;
  logic          w_unused;

  // Node bit points at the LRU child:
  // 0 -> left subtree, 1 -> right subtree.
  function automatic logic [NB-1:0] touch(
    input logic [NB-1:0]    t,
    input logic [WAY_W-1:0] w
  );
    logic [NB-1:0] r;
    int unsigned   n;
    logic          d;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d = w[WAY_W-1-l];
      for (int k = 0; k < NB; k++)
        if (k == n) r[k] = ~d;
      n = 2 * n + (d ? 2 : 1);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] leaf(
    input logic [NB-1:0] t
  );
    logic [WAY_W-1:0] v;
    int unsigned      n;
    logic             d;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d = 1'b0;
      for (int k = 0; k < NB; k++)
        if (k == n) d = t[k];
      v[WAY_W-1-l] = d;
      n = 2 * n + (d ? 2 : 1);
    end
    return v;
  endfunction

  // Update touch lands after the lookup touch.
  assign w_t1 = lk_touch_i ? touch(r_tree, lk_way_i) : r_tree;
  assign w_t2 = up_touch_i ? touch(w_t1, up_way_i) : w_t1;

  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) r_tree <= '0;
    else          r_tree <= w_t2;

  assign victim_o = leaf(r_tree);
  assign w_unused = full_alloc_i;
`else
  logic [WAY_W-1:0] r_ptr;
  logic             w_unused;

  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni)          r_ptr <= '0;
    else if (full_alloc_i) r_ptr <= r_ptr + WAY_W'(1);

  assign victim_o = r_ptr;
  assign w_unused = ^{lk_touch_i, lk_way_i,
                      up_touch_i, up_way_i};
`endif

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative BTB with 2-bit counters.
// Ports: pc_i lookup -> hit/taken/target;
//   upd_* train port -> redirect_o/redirect_pc_o.
// BTB_PLRU_EN selects PLRU, else round-robin.
module branch_target_buffer_sa
  import maverickOne_pkg::*;
#(
  parameter int unsigned XLEN     = maverickOne_pkg::XLEN,
  parameter int unsigned NUM_SETS = NUM_BTB_SETS,
  parameter int unsigned NUM_WAYS = NUM_BTB_WAYS
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            lookup_valid_i,
  output logic            hit_o,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam int unsigned TGT_W = XLEN - 2;

  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  btb_ctr_t            r_ctr   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [TGT_W-1:0]    r_tgt   [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;

  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic [WAY_W-1:0] w_uhit_way;
  logic             w_has_inv;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim [NUM_SETS];
  logic [WAY_W-1:0] w_wr_way;
  logic             w_wr;
  logic             w_alloc;

  logic [XLEN-1:0]  w_pc4;
  logic [XLEN-1:0]  w_actual;
  logic [XLEN-1:0]  w_pred;
  logic             w_unused;

  assign w_idx  = pc_i[IDX_W+1:2];
  assign w_tag  = pc_i[XLEN-1:IDX_W+2];
  assign w_uidx = upd_pc_i[IDX_W+1:2];
  assign w_utag = upd_pc_i[XLEN-1:IDX_W+2];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (r_valid[w_idx][w] &&
          r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
  end

  assign hit_o = w_hit;
  assign predict_taken_o =
    w_hit & r_ctr[w_idx][w_hit_way][1];
  assign target_o = w_hit ?
    {r_tgt[w_idx][w_hit_way], 2'b00} : '0;

  always_comb begin
    w_uhit     = 1'b0;
    w_uhit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (r_valid[w_uidx][w] &&
          r_tag[w_uidx][w] == w_utag) begin
        w_uhit     = 1'b1;
        w_uhit_way = WAY_W'(w);
      end
  end

  // Descending scan so the lowest invalid way wins.
  always_comb begin
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!r_valid[w_uidx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
  end

  assign w_wr_way = w_uhit    ? w_uhit_way :
                    w_has_inv ? w_inv_way  :
                                w_victim[w_uidx];

  // Flush drops the update entirely.
  assign w_wr    = upd_valid_i & ~flush_i &
                   (w_uhit | upd_taken_i);
  assign w_alloc = w_wr & ~w_uhit;

  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          r_ctr[s][w] <= '0;
      end
    end else if (flush_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        r_valid[s] <= '0;
    end else if (w_wr) begin
      if (w_alloc) begin
        r_valid[w_uidx][w_wr_way] <= 1'b1;
        r_ctr[w_uidx][w_wr_way]   <= BTB_CTR_WEAK_TAKEN;
      end else begin
        r_ctr[w_uidx][w_wr_way] <=
          btb_ctr_next(r_ctr[w_uidx][w_wr_way],
                       upd_taken_i);
      end
    end

  // Tag/target are qualified by valid; no reset.
  always_ff @(posedge clk_i)
    if (w_wr && upd_taken_i) begin
      r_tag[w_uidx][w_wr_way] <= w_utag;
      r_tgt[w_uidx][w_wr_way] <= upd_target_i[XLEN-1:2];
    end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_rep
    btb_replacement #(
      .NUM_WAYS (NUM_WAYS)
    ) u_rep (
      .clk_i,
      .arst_ni,
      .lk_touch_i   (lookup_valid_i & w_hit &
                     (w_idx == IDX_W'(s))),
      .lk_way_i     (w_hit_way),
      .up_touch_i   (w_wr & (w_uidx == IDX_W'(s))),
      .up_way_i     (w_wr_way),
      .full_alloc_i (w_alloc & ~w_has_inv &
                     (w_uidx == IDX_W'(s))),
      .victim_o     (w_victim[s])
    );
  end

  assign w_pc4    = upd_pc_i + XLEN'(4);
  assign w_actual = upd_taken_i ? upd_target_i : w_pc4;
  assign w_pred   = upd_pred_taken_i ?
                    upd_pred_target_i : w_pc4;

  assign redirect_o    = upd_valid_i & (w_actual != w_pred);
  assign redirect_pc_o = w_actual;

  assign w_unused = ^pc_i[1:0];

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Self-checking bench for branch_target_buffer_sa.
// Vector table + scoreboard queue, XLEN=32, 16x2.
module tb_branch_target_buffer_sa;

`ifdef BTB_PLRU_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        lookup_valid_i = 1'b0;
  logic        hit_o;
  logic        predict_taken_o;
  logic [31:0] target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = '0;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk_i = ~clk_i;

  branch_target_buffer_sa #(
    .XLEN     (32),
    .NUM_SETS (16),
    .NUM_WAYS (2)
  ) dut (
    .clk_i             (clk_i),
    .arst_ni           (arst_ni),
    .flush_i           (flush_i),
    .pc_i              (pc_i),
    .lookup_valid_i    (lookup_valid_i),
    .hit_o             (hit_o),
    .predict_taken_o   (predict_taken_o),
    .target_o          (target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_target_i      (upd_target_i),
    .upd_taken_i       (upd_taken_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  typedef struct {
    bit          fl;
    logic [31:0] pc;
    bit          eh;
    bit          ept;
    logic [31:0] et;
    bit          uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    bit          tk;
    bit          ptk;
    logic [31:0] ptgt;
    bit          erd;
    logic [31:0] erpc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    bit fl, logic [31:0] pc,
    bit eh, bit ept, logic [31:0] et,
    bit uv, logic [31:0] upc, logic [31:0] utgt,
    bit tk, bit ptk, logic [31:0] ptgt,
    bit erd, logic [31:0] erpc);
    vec_t v;
    v.fl = fl;  v.pc = pc;
    v.eh = eh;  v.ept = ept; v.et = et;
    v.uv = uv;  v.upc = upc; v.utgt = utgt;
    v.tk = tk;  v.ptk = ptk; v.ptgt = ptgt;
    v.erd = erd; v.erpc = erpc;
    return v;
  endfunction

  function automatic vec_t lk(
    logic [31:0] pc, bit eh, bit ept, logic [31:0] et);
    return mk(0, pc, eh, ept, et, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    flush_i           = v.fl;
    pc_i              = v.pc;
    lookup_valid_i    = 1'b1;
    upd_valid_i       = v.uv;
    upd_pc_i          = v.upc;
    upd_target_i      = v.utgt;
    upd_taken_i       = v.tk;
    upd_pred_taken_i  = v.ptk;
    upd_pred_target_i = v.ptgt;
    sb.push_back(v);
  endtask

  task automatic idle();
    flush_i     = 1'b0;
    upd_valid_i = 1'b0;
  endtask

  task automatic check_out(int i);
    vec_t e;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d sb_empty", i), 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d hit", i), 32'(hit_o), 32'(e.eh));
    chk($sformatf("v%0d pt", i),
        32'(predict_taken_o), 32'(e.ept));
    chk($sformatf("v%0d tgt", i), target_o, e.et);
    chk($sformatf("v%0d rd", i),
        32'(redirect_o), 32'(e.erd));
    if (e.uv)
      chk($sformatf("v%0d rpc", i), redirect_pc_o, e.erpc);
  endtask

  initial begin
    // reset state
    vecs.push_back(lk(32'h100, 0, 0, 0));
    // allocate; same-cycle lookup sees old state
    vecs.push_back(mk(0, 32'h100, 0, 0, 0,
      1, 32'h100, 32'h200, 1, 0, 0, 1, 32'h200));
    // ctr 2 -> three not-taken, floored at 0
    vecs.push_back(mk(0, 32'h100, 1, 1, 32'h200,
      1, 32'h100, 0, 0, 1, 32'h200, 1, 32'h104));
    vecs.push_back(mk(0, 32'h100, 1, 0, 32'h200,
      1, 32'h100, 0, 0, 0, 0, 0, 32'h104));
    vecs.push_back(mk(0, 32'h100, 1, 0, 32'h200,
      1, 32'h100, 0, 0, 0, 0, 0, 32'h104));
    // five taken from 0: 1,2,3,3,3
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 32'h100, 1, k >= 2, 32'h200,
        1, 32'h100, 32'h200, 1, 1, 32'h200, 0, 32'h200));
    // ctr 3 -> 2 -> 1 (a wrap would give pt=0 early)
    vecs.push_back(mk(0, 32'h100, 1, 1, 32'h200,
      1, 32'h100, 0, 0, 1, 32'h200, 1, 32'h104));
    vecs.push_back(mk(0, 32'h100, 1, 1, 32'h200,
      1, 32'h100, 0, 0, 0, 0, 0, 32'h104));
    // conflict in set 0
    vecs.push_back(mk(0, 32'h100, 1, 0, 32'h200,
      1, 32'h140, 32'h240, 1, 0, 0, 1, 32'h240));
    vecs.push_back(lk(32'h140, 1, 1, 32'h240));
    vecs.push_back(lk(32'h100, 1, 0, 32'h200));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0,
      1, 32'h180, 32'h280, 1, 1, 32'h280, 0, 32'h280));
    vecs.push_back(lk(32'h180, 1, 1, 32'h280));
    vecs.push_back(lk(32'h100, P, 0, P ? 32'h200 : 32'h0));
    vecs.push_back(lk(32'h140, !P, !P,
                      P ? 32'h0 : 32'h240));
    // pc+4 wraps to 0, matches predicted target 0
    vecs.push_back(mk(0, 32'h0, 0, 0, 0,
      1, 32'hFFFF_FFFC, 0, 0, 1, 32'h0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0,
      1, 32'hFFFF_FFFC, 32'h8, 1, 0, 32'h0, 1, 32'h8));
    // flush wins over update; lookup sees pre-flush
    vecs.push_back(mk(1, 32'h180, 1, 1, 32'h280,
      1, 32'h300, 32'h400, 1, 0, 0, 1, 32'h400));
    vecs.push_back(lk(32'h300, 0, 0, 0));
    vecs.push_back(lk(32'h100, 0, 0, 0));
    vecs.push_back(lk(32'h180, 0, 0, 0));
    vecs.push_back(lk(32'hFFFF_FFFC, 0, 0, 0));

    repeat (2) @(posedge clk_i);
    #2 arst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk_i);
      #1 drive(vecs[i]);
      @(negedge clk_i);
      check_out(i);
    end

    // mid-operation asynchronous reset
    @(posedge clk_i);
    #1 drive(mk(0, 32'h500, 0, 0, 0,
      1, 32'h500, 32'h600, 1, 1, 32'h600, 0, 32'h600));
    @(negedge clk_i);
    check_out(100);
    @(posedge clk_i);
    #1 idle();
    pc_i = 32'h500;
    #1 chk("pre_rst hit", 32'(hit_o), 32'd1);
    chk("pre_rst tgt", target_o, 32'h600);
    arst_ni = 1'b0;
    #1 chk("arst hit", 32'(hit_o), 32'd0);
    chk("arst tgt", target_o, 32'h0);
    chk("arst pt", 32'(predict_taken_o), 32'd0);
    @(posedge clk_i);
    #2 arst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst hit", 32'(hit_o), 32'd0);
    chk("idle rd", 32'(redirect_o), 32'd0);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
